// File: rtl/full_adder_pkg.sv
// Bit-level full-adder equations shared by the adder cell.
package full_adder_pkg;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell; the ripple chain is built from these.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational sum/carry/overflow and a
// registered copy captured on enable.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             en,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             ovf,
  output logic [WIDTH-1:0] S_q,
  output logic             C_out_q,
  output logic             ovf_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  assign w_c[0] = C_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign S     = w_s;
  assign C_out = w_c[WIDTH];
  assign ovf   = w_c[WIDTH] ^ w_c[WIDTH-1];

  // Output capture register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (en) begin
      r_s    <= w_s;
      r_cout <= w_c[WIDTH];
      r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end else begin
      r_s    <= r_s;
      r_cout <= r_cout;
      r_ovf  <= r_ovf;
    end
  end

  assign S_q     = r_s;
  assign C_out_q = r_cout;
  assign ovf_q   = r_ovf;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8 against an
// arithmetic model, plus hand-computed directed vectors.
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cin;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic [0:0] s1, s1_q;
  logic       c1, o1, c1_q, o1_q;
  logic [7:0] s8, s8_q;
  logic       c8, o8, c8_q, o8_q;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .C_in(cin), .en(en),
    .S(s1), .C_out(c1), .ovf(o1), .S_q(s1_q), .C_out_q(c1_q), .ovf_q(o1_q)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .C_in(cin), .en(en),
    .S(s8), .C_out(c8), .ovf(o8), .S_q(s8_q), .C_out_q(c8_q), .ovf_q(o8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed overflow: true two's-complement sum falls outside the w-bit range.
  function automatic logic ovf_model(input int w, input int a, input int b, input int c);
    int sa, sb, r;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa + sb + c;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  logic [1:0] m1;
  logic [8:0] m8;
  logic       m1_o, m8_o;
  assign m1   = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
  assign m8   = {1'b0, a8} + {1'b0, b8} + {8'd0, cin};
  assign m1_o = ovf_model(1, int'(a1), int'(b1), int'(cin));
  assign m8_o = ovf_model(8, int'(a8), int'(b8), int'(cin));

  logic [2:0] e1_q;
  logic [9:0] e8_q;
  always @(posedge clk) begin
    if (rst) begin
      e1_q <= 3'd0;
      e8_q <= 10'd0;
    end else if (en) begin
      e1_q <= {m1_o, m1};
      e8_q <= {m8_o, m8};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_s1",    32'(s1),   32'(m1[0]));
      check("m_c1",    32'(c1),   32'(m1[1]));
      check("m_o1",    32'(o1),   32'(m1_o));
      check("m_s1_q",  32'(s1_q), 32'(e1_q[0]));
      check("m_c1_q",  32'(c1_q), 32'(e1_q[1]));
      check("m_o1_q",  32'(o1_q), 32'(e1_q[2]));
      check("m_s8",    32'(s8),   32'(m8[7:0]));
      check("m_c8",    32'(c8),   32'(m8[8]));
      check("m_o8",    32'(o8),   32'(m8_o));
      check("m_s8_q",  32'(s8_q), 32'(e8_q[7:0]));
      check("m_c8_q",  32'(c8_q), 32'(e8_q[8]));
      check("m_o8_q",  32'(o8_q), 32'(e8_q[9]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] exp_s_tbl;
  logic [7:0] exp_c_tbl;
  logic [2:0] vec;

  initial begin
    exp_s_tbl = 8'b1001_0110;
    exp_c_tbl = 8'b1110_1000;
    rst = 1'b1; en = 1'b0; cin = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_s1_q", 32'(s1_q), 32'd0);
    check("rst_c1_q", 32'(c1_q), 32'd0);
    check("rst_s8_q", 32'(s8_q), 32'd0);
    check("rst_o8_q", 32'(o8_q), 32'd0);

    // Exhaustive 1-bit truth table.
    for (int i = 0; i < 8; i++) begin
      step();
      rst = 1'b0;
      vec = i[2:0];
      a1 = vec[2]; b1 = vec[1]; cin = vec[0];
      @(negedge clk);
      check("t1_s", 32'(s1), 32'(exp_s_tbl[i]));
      check("t1_c", 32'(c1), 32'(exp_c_tbl[i]));
    end

    // 1+1+0: immediate combinational result, registered one edge later.
    step();
    a1 = 1'b1; b1 = 1'b1; cin = 1'b0; en = 1'b1;
    #1;
    check("t2_c_now", 32'(c1), 32'd1);
    check("t2_s_now", 32'(s1), 32'd0);
    step();
    en = 1'b0; a1 = 1'b0; b1 = 1'b0; cin = 1'b1;
    @(negedge clk);
    check("t2_c_q", 32'(c1_q), 32'd1);
    check("t2_s_q", 32'(s1_q), 32'd0);
    check("t2_o_q", 32'(o1_q), 32'd1);
    step();
    @(negedge clk);
    check("t3_hold_c_q", 32'(c1_q), 32'd1);
    check("t3_hold_o_q", 32'(o1_q), 32'd1);

    // Reset with enable high clears registers; comb path keeps working.
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    check("t3_comb_in_rst", 32'(s1), 32'd1);
    step();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check("t3_rst_s_q", 32'(s1_q), 32'd0);
    check("t3_rst_c_q", 32'(c1_q), 32'd0);
    check("t3_rst_o_q", 32'(o1_q), 32'd0);

    // 8-bit boundaries.
    step(); a8 = 8'hFF; b8 = 8'h01; cin = 1'b0;
    @(negedge clk);
    check("t4_s", 32'(s8), 32'h00); check("t4_c", 32'(c8), 32'd1); check("t4_o", 32'(o8), 32'd0);
    step(); a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1;
    @(negedge clk);
    check("t4b_s", 32'(s8), 32'hFF); check("t4b_c", 32'(c8), 32'd1);
    step(); a8 = 8'h7F; b8 = 8'h01; cin = 1'b0;
    @(negedge clk);
    check("t5_s", 32'(s8), 32'h80); check("t5_o", 32'(o8), 32'd1); check("t5_c", 32'(c8), 32'd0);
    step(); a8 = 8'h80; b8 = 8'h80; cin = 1'b0;
    @(negedge clk);
    check("t5b_s", 32'(s8), 32'h00); check("t5b_o", 32'(o8), 32'd1); check("t5b_c", 32'(c8), 32'd1);
    step(); a8 = 8'h00; b8 = 8'h00; cin = 1'b0;
    @(negedge clk);
    check("t5c_s", 32'(s8), 32'h00); check("t5c_c", 32'(c8), 32'd0);

    // Random sweep with capture enabled and occasional mid-stream reset.
    en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      step();
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      cin = 1'($urandom);
      rst = ((k % 250) == 100);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
